// File: rtl/re_cam_pkg.sv
// Shared constants for the RE camera readout capture: state encoding, row count,
// default widths and pixel index width.
package re_cam_pkg;

    localparam int N_ROWS     = 2;
    localparam int DATA_W_DEF = 8;
    localparam int N_COLS_DEF = 2;
    localparam int EXP_W_DEF  = 8;
    localparam int N_PIX_DEF  = N_ROWS * N_COLS_DEF;
    localparam int PIX_IDX_W  = (N_PIX_DEF > 1) ? $clog2(N_PIX_DEF) : 1;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_ERASE  = 3'd1;
    localparam logic [ST_W-1:0] ST_EXPOSE = 3'd2;
    localparam logic [ST_W-1:0] ST_READ1  = 3'd3;
    localparam logic [ST_W-1:0] ST_READ2  = 3'd4;

endpackage

// File: rtl/re_pixel_stream.sv
// Output shadow buffer holding one committed frame and its exposure length,
// serialised one pixel per accepted handshake.
module re_pixel_stream
    import re_cam_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_COLS = N_COLS_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_i,
    input  logic [N_ROWS*N_COLS*DATA_W-1:0] frame_i,
    input  logic [EXP_W-1:0]                exp_i,
    output logic                            empty_o,
    output logic [EXP_W-1:0]                exp_o,
    output logic                            px_valid_o,
    input  logic                            px_ready_i,
    output logic [DATA_W-1:0]               px_data_o,
    output logic                            px_last_o
);

    localparam int N_PIX = N_ROWS * N_COLS;
    localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    logic                       full_q,  full_d;
    logic [IDX_W-1:0]           idx_q,   idx_d;
    logic [N_PIX*DATA_W-1:0]    frame_q, frame_d;
    logic [EXP_W-1:0]           exp_q,   exp_d;
    logic                       accept;
    logic                       last_px;

    // Handshake: px_valid_o is a registered level; while it is high px_data_o and
    // px_last_o do not change. A pixel transfers on a rising edge where both
    // px_valid_o and px_ready_i are high. Valid never depends on ready.
    assign accept     = full_q & px_ready_i;
    assign last_px    = (idx_q == LAST_IDX);
    assign px_valid_o = full_q;
    assign px_data_o  = frame_q[idx_q*DATA_W +: DATA_W];
    assign px_last_o  = full_q & last_px;
    assign empty_o    = ~full_q;
    assign exp_o      = exp_q;

    always_comb begin
        full_d  = full_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        exp_d   = exp_q;
        if (load_i && !full_q) begin
            full_d  = 1'b1;
            idx_d   = '0;
            frame_d = frame_i;
            exp_d   = exp_i;
        end else if (accept) begin
            if (last_px) begin
                full_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            idx_q   <= '0;
            frame_q <= '0;
            exp_q   <= '0;
        end else begin
            full_q  <= full_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            exp_q   <= exp_d;
        end
    end

endmodule

// File: rtl/re_readout_capture.sv
// Receiving end of the RE_control camera bus: tracks erase/expose/read phases,
// times the exposure, captures two ADC rows and hands frames to the pixel stream.
module re_readout_capture
    import re_cam_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_COLS = N_COLS_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     erase,
    input  logic                     expose,
    input  logic                     NRE_1,
    input  logic                     NRE_2,
    input  logic                     ADC,
    input  logic [N_COLS*DATA_W-1:0] pix_data,
    input  logic                     clr_err,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [DATA_W-1:0]        px_data,
    output logic                     px_last,
    output logic                     frame_done,
    output logic [EXP_W-1:0]         exp_cycles,
    output logic [7:0]               frame_cnt,
    output logic                     busy,
    output logic                     proto_err,
    output logic                     overrun,
    output logic [ST_W-1:0]          dbg_state
);

    localparam int ROW_W = N_COLS * DATA_W;

    logic              rst_n;
    logic [ST_W-1:0]   state_q, state_d;
    logic              adc_q;
    logic [EXP_W-1:0]  exp_cnt_q, exp_cnt_d;
    logic [ROW_W-1:0]  row0_q, row0_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              overrun_q, overrun_d;

    logic adc_rise;
    logic rd1_ok;
    logic rd2_ok;
    logic in_read;
    logic abort;
    logic commit;
    logic buf_empty;
    logic load;
    logic drop;
    logic bad_adc;
    logic err_set;

    assign rst_n = reset;

    assign adc_rise = ADC & ~adc_q;
    assign rd1_ok   = ~NRE_1 & NRE_2;
    assign rd2_ok   = NRE_1 & ~NRE_2;
    assign in_read  = (state_q == ST_READ1) || (state_q == ST_READ2);
    assign abort    = erase & in_read;
    assign commit   = (state_q == ST_READ2) & adc_rise & rd2_ok & ~abort;
    // A buffer draining its last pixel this cycle still counts as full.
    assign load     = commit & buf_empty;
    assign drop     = commit & ~buf_empty;

    assign bad_adc = adc_rise & ((state_q == ST_READ1) ? ~rd1_ok :
                                 (state_q == ST_READ2) ? ~rd2_ok : 1'b1);
    assign err_set = (~NRE_1 & ~NRE_2) | bad_adc | (erase & expose) | abort;

    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        row0_d    = row0_q;
        case (state_q)
            ST_IDLE: begin
                if (erase) state_d = ST_ERASE;
            end
            ST_ERASE: begin
                if (expose) begin
                    state_d   = ST_EXPOSE;
                    exp_cnt_d = EXP_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (expose) begin
                    if (exp_cnt_q != {EXP_W{1'b1}}) exp_cnt_d = exp_cnt_q + 1'b1;
                end else begin
                    state_d = ST_READ1;
                end
            end
            ST_READ1: begin
                if (abort) begin
                    state_d = ST_ERASE;
                end else if (adc_rise && rd1_ok) begin
                    row0_d  = pix_data;
                    state_d = ST_READ2;
                end
            end
            ST_READ2: begin
                if (abort)       state_d = ST_ERASE;
                else if (commit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_done_d = load;
        frame_cnt_d  = frame_cnt_q + {7'd0, load};
        proto_err_d  = err_set | (proto_err_q & ~clr_err);
        overrun_d    = drop | (overrun_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            adc_q        <= 1'b0;
            exp_cnt_q    <= '0;
            row0_q       <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            proto_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            adc_q        <= ADC;
            exp_cnt_q    <= exp_cnt_d;
            row0_q       <= row0_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            proto_err_q  <= proto_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Row 1 goes straight from the bus into the buffer on the commit edge.
    re_pixel_stream #(
        .DATA_W (DATA_W),
        .N_COLS (N_COLS),
        .EXP_W  (EXP_W)
    ) u_stream (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .frame_i    ({pix_data, row0_q}),
        .exp_i      (exp_cnt_q),
        .empty_o    (buf_empty),
        .exp_o      (exp_cycles),
        .px_valid_o (px_valid),
        .px_ready_i (px_ready),
        .px_data_o  (px_data),
        .px_last_o  (px_last)
    );

    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q != ST_IDLE);
    assign proto_err  = proto_err_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule
